// File: rtl/sprite_ram_loader_pkg.sv
// Shared types and constants for the sprite-RAM loader: FSM states,
// sprite geometry, palette codes and the packed-word pixel selector.
package sprite_ram_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UNPACK = 2'd1,
      ST_FILL   = 2'd2
   } state_e;

   localparam int H_SIZE       = 16;
   localparam int V_SIZE       = 16;
   localparam int PIX_W        = 2;
   localparam int PIX_PER_WORD = 16;

   localparam logic [1:0] PAL_TRANSPARENT = 2'd0;
   localparam logic [1:0] PAL_COLOR1      = 2'd1;
   localparam logic [1:0] PAL_COLOR2      = 2'd2;
   localparam logic [1:0] PAL_COLOR3      = 2'd3;

   localparam logic [3:0] WORD_LAST = 4'(PIX_PER_WORD - 1);
   localparam logic [7:0] FILL_LAST = 8'(H_SIZE * V_SIZE - 1);

   function automatic logic [PIX_W-1:0] pixel_of(
      input logic [PIX_W*PIX_PER_WORD-1:0] word,
      input logic [3:0]                    k
   );
      return word[{k, 1'b0} +: PIX_W];
   endfunction

endpackage

// File: rtl/sprite_ram_loader.sv
// Writes sprite RAM either by unpacking 16-pixel packed words or by filling
// a whole 16x16 slot with one palette code; all RAM-side outputs are registered.
module sprite_ram_loader
   import sprite_ram_loader_pkg::*;
#(
   parameter int ADDR   = 10,
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [WORD_W-1:0] wr_data,
   input  logic [ADDR-5:0]   wr_waddr,
   input  logic              fill_start,
   input  logic [1:0]        fill_sid,
   input  logic [1:0]        fill_code,
   output logic              we,
   output logic [ADDR-1:0]   addr_w,
   output logic [1:0]        pixel_out,
   output logic              busy,
   output logic              done
);

   state_e              state_q, state_d;
   logic [3:0]          wcnt_q, wcnt_d, wnext;
   logic [7:0]          fcnt_q, fcnt_d, fnext;
   logic [WORD_W-1:0]   data_q, data_d;
   logic [ADDR-5:0]     base_q, base_d;
   logic [1:0]          sid_q, sid_d;
   logic [1:0]          code_q, code_d;
   logic                we_q, we_d;
   logic [ADDR-1:0]     addr_q, addr_d;
   logic [1:0]          pix_q, pix_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   // State, counters, latches and registered RAM-side outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         wcnt_q  <= 4'd0;
         fcnt_q  <= 8'd0;
         data_q  <= '0;
         base_q  <= '0;
         sid_q   <= 2'd0;
         code_q  <= PAL_TRANSPARENT;
         we_q    <= 1'b0;
         addr_q  <= '0;
         pix_q   <= PAL_TRANSPARENT;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         fcnt_q  <= fcnt_d;
         data_q  <= data_d;
         base_q  <= base_d;
         sid_q   <= sid_d;
         code_q  <= code_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         pix_q   <= pix_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next state; the _d outputs describe the write shown in the following cycle.
   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      fcnt_d   = fcnt_q;
      data_d   = data_q;
      base_d   = base_q;
      sid_d    = sid_q;
      code_d   = code_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      pix_d    = pix_q;
      done_d   = 1'b0;
      wr_ready = 1'b0;
      wnext    = wcnt_q + 4'd1;
      fnext    = fcnt_q + 8'd1;

      case (state_q)
         ST_IDLE: begin
            wr_ready = !fill_start;
            if (fill_start) begin
               sid_d   = fill_sid;
               code_d  = fill_code;
               fcnt_d  = 8'd0;
               we_d    = 1'b1;
               addr_d  = ADDR'({fill_sid, 8'h00});
               pix_d   = fill_code;
               state_d = ST_FILL;
            end else if (wr_valid) begin
               data_d  = wr_data;
               base_d  = wr_waddr;
               wcnt_d  = 4'd0;
               we_d    = 1'b1;
               addr_d  = {wr_waddr, 4'h0};
               pix_d   = pixel_of(wr_data, 4'd0);
               state_d = ST_UNPACK;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_UNPACK: begin
            wr_ready = (wcnt_q == WORD_LAST);
            if (wcnt_q != WORD_LAST) begin
               wcnt_d = wnext;
               we_d   = 1'b1;
               addr_d = {base_q, wnext};
               pix_d  = pixel_of(data_q, wnext);
            end else if (wr_valid) begin
               // Chained word: first pixel of the new word follows with no gap.
               done_d = 1'b1;
               data_d = wr_data;
               base_d = wr_waddr;
               wcnt_d = 4'd0;
               we_d   = 1'b1;
               addr_d = {wr_waddr, 4'h0};
               pix_d  = pixel_of(wr_data, 4'd0);
            end else begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_FILL: begin
            if (fcnt_q != FILL_LAST) begin
               fcnt_d = fnext;
               we_d   = 1'b1;
               addr_d = ADDR'({sid_q, fnext});
               pix_d  = code_q;
            end else begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign we        = we_q;
   assign addr_w    = addr_q;
   assign pixel_out = pix_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Self-checking bench: a queue-of-pending-writes reference model checked every
// cycle, a vector table, hand-written corner sequences and a RAM raster scan.
module tb_sprite_ram_loader;
   import sprite_ram_loader_pkg::*;

   localparam int ADDR   = 10;
   localparam int WORD_W = 32;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              wr_valid, wr_ready;
   logic [WORD_W-1:0] wr_data;
   logic [ADDR-5:0]   wr_waddr;
   logic              fill_start;
   logic [1:0]        fill_sid, fill_code;
   logic              we;
   logic [ADDR-1:0]   addr_w;
   logic [1:0]        pixel_out;
   logic              busy, done;

   always #5 clk = ~clk;

   sprite_ram_loader #(.ADDR(ADDR), .WORD_W(WORD_W)) dut (
      .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_data(wr_data), .wr_waddr(wr_waddr), .fill_start(fill_start),
      .fill_sid(fill_sid), .fill_code(fill_code), .we(we), .addr_w(addr_w),
      .pixel_out(pixel_out), .busy(busy), .done(done)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the list of writes still to be shown, one per cycle.
   typedef struct packed {
      logic [9:0] addr;
      logic [1:0] pix;
      logic       last;
      logic       word;
   } wr_t;

   wr_t        mq[$];
   logic       m_done;
   logic [9:0] m_last_addr;
   logic [1:0] m_last_pix;
   logic [1:0] shadow [0:1023];
   logic [1:0] ram    [0:1023];

   function automatic logic model_ready();
      if (mq.size() == 0) return !fill_start;
      return mq[0].word && mq[0].last;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      logic rdy, acc_f, acc_w;
      wr_t  e;
      if (!reset_n) begin
         mq.delete();
         m_done      = 1'b0;
         m_last_addr = 10'd0;
         m_last_pix  = 2'd0;
      end else begin
         rdy   = model_ready();
         acc_f = (mq.size() == 0) && fill_start;
         acc_w = !acc_f && wr_valid && rdy;
         if (mq.size() > 0) begin
            shadow[mq[0].addr] = mq[0].pix;
            m_last_addr = mq[0].addr;
            m_last_pix  = mq[0].pix;
            m_done      = mq[0].last;
            void'(mq.pop_front());
         end else begin
            m_done = 1'b0;
         end
         if (acc_f) begin
            for (int i = 0; i < 256; i++) begin
               e.addr = {fill_sid, 8'(i)};
               e.pix  = fill_code;
               e.last = (i == 255);
               e.word = 1'b0;
               mq.push_back(e);
            end
         end
         if (acc_w) begin
            for (int i = 0; i < 16; i++) begin
               e.addr = {wr_waddr, 4'(i)};
               e.pix  = 2'((wr_data >> (2 * i)) & 32'd3);
               e.last = (i == 15);
               e.word = 1'b1;
               mq.push_back(e);
            end
         end
      end
   end

   always @(posedge clk) begin
      if (we) ram[addr_w] <= pixel_out;
   end

   // Per-cycle comparison against the model plus event logging.
   int         cyc = 0, n_we = 0, n_done = 0, n_hs = 0, n_rdy_busy = 0;
   logic [9:0] wlog_addr [0:65535];
   logic [1:0] wlog_pix  [0:65535];
   int         wlog_cyc  [0:65535];

   always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
         chk("rst_we", 32'(we), 32'd0);
         chk("rst_addr", 32'(addr_w), 32'd0);
         chk("rst_pix", 32'(pixel_out), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_done", 32'(done), 32'd0);
      end else begin
         chk("we", 32'(we), 32'(mq.size() > 0));
         chk("addr", 32'(addr_w), (mq.size() > 0) ? 32'(mq[0].addr) : 32'(m_last_addr));
         chk("pix", 32'(pixel_out), (mq.size() > 0) ? 32'(mq[0].pix) : 32'(m_last_pix));
         chk("done", 32'(done), 32'(m_done));
         chk("busy", 32'(busy), 32'(mq.size() > 0));
         chk("wr_ready", 32'(wr_ready), 32'(model_ready()));
      end
      if (we === 1'b1) begin
         wlog_addr[n_we] = addr_w;
         wlog_pix[n_we]  = pixel_out;
         wlog_cyc[n_we]  = cyc;
         n_we++;
      end
      if (done === 1'b1) n_done++;
      if (wr_valid && wr_ready === 1'b1) n_hs++;
      if (wr_ready === 1'b1 && busy === 1'b1) n_rdy_busy++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int want_done, input string name);
      logic ok = 1'b0;
      for (int k = 0; k < 600; k++) begin
         tick();
         if (n_done >= want_done && busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      chk(name, 32'(ok), 32'd1);
   endtask

   task automatic wait_hs(input int want_hs, input string name);
      logic ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         tick();
         if (n_hs >= want_hs) begin
            ok = 1'b1;
            break;
         end
      end
      chk(name, 32'(ok), 32'd1);
   endtask

   typedef struct {
      logic        is_fill;
      logic [1:0]  sid;
      logic [1:0]  code;
      logic [31:0] data;
      logic [5:0]  waddr;
      logic [9:0]  exp_addr0;
      logic [1:0]  exp_pix0;
      logic [9:0]  exp_addr_last;
      int          exp_n;
      int          exp_rdy_busy;
      logic        chk_pattern;
   } vec_t;

   vec_t        vt [6];
   logic [31:0] spr [16];

   initial begin
      int b_we, b_done, b_hs, b_rb;

      for (int a = 0; a < 1024; a++) begin
         shadow[a] = 2'd0;
         ram[a]    = 2'd0;
      end
      wr_valid = 1'b0; wr_data = '0; wr_waddr = '0;
      fill_start = 1'b0; fill_sid = 2'd0; fill_code = 2'd0;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      repeat (3) tick();
      chk("reset_we", 32'(we), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_addr", 32'(addr_w), 32'd0);
      chk("reset_pix", 32'(pixel_out), 32'd0);
      reset_n = 1'b1;
      chk("ready_after_reset", 32'(wr_ready), 32'd1);
      tick();

      vt[0] = '{1'b0, 2'd0, 2'd0, 32'hE4E4_E4E4, 6'h05, 10'h050, 2'd0, 10'h05F, 16, 1, 1'b1};
      vt[1] = '{1'b1, 2'd2, PAL_COLOR1, 32'h0, 6'h00, 10'h200, PAL_COLOR1, 10'h2FF, 256, 0, 1'b0};
      vt[2] = '{1'b0, 2'd0, 2'd0, 32'h0000_0003, 6'h3F, 10'h3F0, 2'd3, 10'h3FF, 16, 1, 1'b0};
      vt[3] = '{1'b1, 2'd3, PAL_COLOR3, 32'h0, 6'h00, 10'h300, PAL_COLOR3, 10'h3FF, 256, 0, 1'b0};
      vt[4] = '{1'b1, 2'd0, PAL_TRANSPARENT, 32'h0, 6'h00, 10'h000, PAL_TRANSPARENT, 10'h0FF, 256, 0, 1'b0};
      vt[5] = '{1'b0, 2'd0, 2'd0, 32'hC000_0002, 6'h00, 10'h000, PAL_COLOR2, 10'h00F, 16, 1, 1'b0};

      for (int v = 0; v < 6; v++) begin
         b_we = n_we; b_done = n_done; b_rb = n_rdy_busy;
         if (vt[v].is_fill) begin
            fill_start = 1'b1; fill_sid = vt[v].sid; fill_code = vt[v].code;
         end else begin
            wr_valid = 1'b1; wr_data = vt[v].data; wr_waddr = vt[v].waddr;
         end
         tick();
         fill_start = 1'b0; wr_valid = 1'b0;
         wait_done(b_done + 1, "vec_timeout");
         chk("vec_nwrites", 32'(n_we - b_we), 32'(vt[v].exp_n));
         chk("vec_ndone", 32'(n_done - b_done), 32'd1);
         chk("vec_addr0", 32'(wlog_addr[b_we]), 32'(vt[v].exp_addr0));
         chk("vec_pix0", 32'(wlog_pix[b_we]), 32'(vt[v].exp_pix0));
         chk("vec_addr_last", 32'(wlog_addr[b_we + vt[v].exp_n - 1]), 32'(vt[v].exp_addr_last));
         chk("vec_rdy_busy", 32'(n_rdy_busy - b_rb), 32'(vt[v].exp_rdy_busy));
         if (vt[v].chk_pattern) begin
            for (int i = 0; i < 16; i++)
               chk("vec_code_seq", 32'(wlog_pix[b_we + i]), 32'(i % 4));
         end
      end

      // Back-to-back words with wr_valid held high.
      b_we = n_we; b_done = n_done; b_hs = n_hs; b_rb = n_rdy_busy;
      wr_valid = 1'b1; wr_data = 32'h1B1B_1B1B; wr_waddr = 6'h11;
      tick();
      wr_data = 32'h5555_AAAA; wr_waddr = 6'h12;
      wait_hs(b_hs + 2, "b2b_hs_timeout");
      wr_valid = 1'b0;
      wait_done(b_done + 2, "b2b_timeout");
      chk("b2b_nwrites", 32'(n_we - b_we), 32'd32);
      chk("b2b_contiguous", 32'(wlog_cyc[b_we + 31] - wlog_cyc[b_we]), 32'd31);
      chk("b2b_second_base", 32'(wlog_addr[b_we + 16]), 32'h120);
      chk("b2b_ndone", 32'(n_done - b_done), 32'd2);
      chk("b2b_rdy_busy", 32'(n_rdy_busy - b_rb), 32'd2);

      // Fill and word offered together: fill first, word right after.
      b_we = n_we; b_done = n_done; b_hs = n_hs;
      fill_start = 1'b1; fill_sid = 2'd1; fill_code = PAL_COLOR2;
      wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF; wr_waddr = 6'h09;
      #1 chk("sim_ready_low", 32'(wr_ready), 32'd0);
      tick();
      fill_start = 1'b0;
      wait_hs(b_hs + 1, "sim_hs_timeout");
      wr_valid = 1'b0;
      wait_done(b_done + 2, "sim_timeout");
      chk("sim_nwrites", 32'(n_we - b_we), 32'd272);
      chk("sim_fill_base", 32'(wlog_addr[b_we]), 32'h100);
      chk("sim_word_base", 32'(wlog_addr[b_we + 256]), 32'h090);
      chk("sim_word_gap", 32'(wlog_cyc[b_we + 256] - wlog_cyc[b_we + 255]), 32'd2);

      // Reset in the middle of a word.
      b_we = n_we; b_done = n_done;
      wr_valid = 1'b1; wr_data = 32'hFFFF_0000; wr_waddr = 6'h20;
      tick();
      wr_valid = 1'b0;
      repeat (7) tick();
      chk("rstmid_cnt7_addr", 32'(addr_w), 32'h207);
      #2 reset_n = 1'b0;
      #1;
      chk("rstmid_we", 32'(we), 32'd0);
      chk("rstmid_addr", 32'(addr_w), 32'd0);
      chk("rstmid_pix", 32'(pixel_out), 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_done", 32'(done), 32'd0);
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (20) tick();
      chk("rstmid_nwrites", 32'(n_we - b_we), 32'd7);
      chk("rstmid_no_done", 32'(n_done - b_done), 32'd0);
      b_we = n_we; b_done = n_done;
      wr_valid = 1'b1; wr_data = 32'hE4E4_E4E4; wr_waddr = 6'h21;
      tick();
      wr_valid = 1'b0;
      wait_done(b_done + 1, "rstmid_new_timeout");
      chk("rstmid_new_nwrites", 32'(n_we - b_we), 32'd16);
      chk("rstmid_new_base", 32'(wlog_addr[b_we]), 32'h210);

      // Randomized traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         wr_valid   = ($urandom_range(0, 3) != 0);
         wr_data    = $urandom;
         wr_waddr   = 6'($urandom);
         fill_start = ($urandom_range(0, 99) == 0);
         fill_sid   = 2'($urandom);
         fill_code  = 2'($urandom);
         tick();
      end
      wr_valid = 1'b0; fill_start = 1'b0;
      repeat (300) tick();

      // Load sprite slot 1 row by row, then raster-scan it.
      for (int r = 0; r < 16; r++) spr[r] = $urandom;
      wr_valid = 1'b1;
      for (int r = 0; r < 16; r++) begin
         b_hs = n_hs;
         wr_data = spr[r]; wr_waddr = {2'd1, 4'(r)};
         wait_hs(b_hs + 1, "sprite_hs_timeout");
      end
      wr_valid = 1'b0;
      repeat (40) tick();
      for (int r = 0; r < V_SIZE; r++)
         for (int c = 0; c < H_SIZE; c++)
            chk("sprite_scan", 32'(ram[{2'd1, 4'(r), 4'(c)}]), (spr[r] >> (2 * c)) & 32'd3);

      for (int a = 0; a < 1024; a++)
         chk("ram_vs_model", 32'(ram[a]), 32'(shadow[a]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
